// File: rtl/crc_pkg.sv
// Shared constants for the CRC burst checker: FSM encoding and the
// ATA UDMA default generator polynomial / preset.
package crc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [15:0] CRC_POLY_ATA = 16'h1021;
    localparam logic [15:0] CRC_SEED_ATA = 16'h4ABA;

endpackage

// File: rtl/crc_step.sv
// Combinational one-word CRC step: shifts DW data bits MSB-first through a
// CW-bit register with an implicit x^CW term, no reflection, no final XOR.
module crc_step
    import crc_pkg::*;
#(
    parameter int              DW   = 16,
    parameter int              CW   = 16,
    parameter logic [CW-1:0]   POLY = CRC_POLY_ATA
) (
    input  logic [CW-1:0] C,
    input  logic [DW-1:0] D,
    output logic [CW-1:0] Q
);

    logic [CW-1:0] acc;

    always_comb begin
        acc = C;
        for (int i = DW - 1; i >= 0; i--) begin
            if (acc[CW-1] ^ D[i]) begin
                acc = (acc << 1) ^ POLY;
            end else begin
                acc = acc << 1;
            end
        end
        Q = acc;
    end

endmodule

// File: rtl/crc_burst_chk.sv
// Burst CRC accumulator and checker: folds data words into a running CRC,
// then compares a received CRC and reports match / sticky mismatch.
module crc_burst_chk
    import crc_pkg::*;
#(
    parameter int            DW   = 16,
    parameter int            CW   = 16,
    parameter logic [CW-1:0] POLY = CRC_POLY_ATA,
    parameter logic [CW-1:0] SEED = CRC_SEED_ATA
) (
    input  logic          CLK4,
    input  logic          RESET_N,
    input  logic          CRC_ARM,
    input  logic          CRC_ENB,
    input  logic [DW-1:0] D,
    input  logic          CHK_STB,
    input  logic [CW-1:0] CHK_D,
    input  logic          ERR_CLR,
    output logic [CW-1:0] CRC_Q,
    output logic [15:0]   WCNT,
    output logic          BUSY,
    output logic          CRC_OK,
    output logic          CRC_ERR,
    output logic [1:0]    STATE_DBG
);

    // Handshake: CRC_ENB and CHK_STB are single-cycle valid qualifiers with no
    // ready/back-pressure; whatever is presented at an edge outside DONE is taken.

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] crc_q, crc_d;
    logic [15:0]   wcnt_q, wcnt_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [CW-1:0] crc_next;
    logic          match;

    crc_step #(
        .DW   (DW),
        .CW   (CW),
        .POLY (POLY)
    ) u_step (
        .C (crc_q),
        .D (D),
        .Q (crc_next)
    );

    assign match = (CHK_D == crc_q);

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        wcnt_d  = wcnt_q;
        ok_d    = ok_q;
        err_d   = ERR_CLR ? 1'b0 : err_q;

        if (!CRC_ARM) begin
            state_d = ST_IDLE;
            crc_d   = SEED;
            wcnt_d  = 16'd0;
            ok_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    // The check strobe wins over a same-cycle data word.
                    if (CHK_STB) begin
                        ok_d    = match;
                        state_d = ST_DONE;
                        if (!match) begin
                            err_d = 1'b1;
                        end
                    end else if (CRC_ENB) begin
                        crc_d   = crc_next;
                        wcnt_d  = (wcnt_q == 16'hFFFF) ? wcnt_q : wcnt_q + 16'd1;
                        state_d = ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    crc_d   = SEED;
                    wcnt_d  = 16'd0;
                    ok_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK4 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            crc_q   <= SEED;
            wcnt_q  <= 16'd0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            wcnt_q  <= wcnt_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign CRC_Q     = crc_q;
    assign WCNT      = wcnt_q;
    assign BUSY      = (state_q == ST_ACCUM);
    assign CRC_OK    = ok_q;
    assign CRC_ERR   = err_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_crc_burst_chk.sv
// Directed and randomised checks of crc_burst_chk at DW=16 (default),
// DW=8 (seed FFFF) and DW=32, all driven from one shared stimulus.
module tb_crc_burst_chk;

    localparam logic [15:0] POLY  = 16'h1021;
    localparam logic [15:0] SEED  = 16'h4ABA;
    localparam logic [15:0] SEED8 = 16'hFFFF;
    localparam logic [1:0]  S_IDLE = 2'd0, S_ACCUM = 2'd1, S_DONE = 2'd2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, arm, enb, chk_stb, err_clr;
    logic [31:0] d;
    logic [15:0] chk_d;

    logic [15:0] crc16, crc8, crc32, wcnt16, wcnt8, wcnt32;
    logic        busy16, busy8, busy32, ok16, ok8, ok32, err16, err8, err32;
    logic [1:0]  st16, st8, st32;

    crc_burst_chk u_dut (
        .CLK4(clk), .RESET_N(rst_n), .CRC_ARM(arm), .CRC_ENB(enb), .D(d[15:0]),
        .CHK_STB(chk_stb), .CHK_D(chk_d), .ERR_CLR(err_clr), .CRC_Q(crc16),
        .WCNT(wcnt16), .BUSY(busy16), .CRC_OK(ok16), .CRC_ERR(err16), .STATE_DBG(st16)
    );

    crc_burst_chk #(.DW(8), .SEED(16'hFFFF)) u_dut8 (
        .CLK4(clk), .RESET_N(rst_n), .CRC_ARM(arm), .CRC_ENB(enb), .D(d[7:0]),
        .CHK_STB(chk_stb), .CHK_D(chk_d), .ERR_CLR(err_clr), .CRC_Q(crc8),
        .WCNT(wcnt8), .BUSY(busy8), .CRC_OK(ok8), .CRC_ERR(err8), .STATE_DBG(st8)
    );

    crc_burst_chk #(.DW(32)) u_dut32 (
        .CLK4(clk), .RESET_N(rst_n), .CRC_ARM(arm), .CRC_ENB(enb), .D(d),
        .CHK_STB(chk_stb), .CHK_D(chk_d), .ERR_CLR(err_clr), .CRC_Q(crc32),
        .WCNT(wcnt32), .BUSY(busy32), .CRC_OK(ok32), .CRC_ERR(err32), .STATE_DBG(st32)
    );

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [15:0] exp16_q[$], exp8_q[$], exp32_q[$];

    logic [15:0] m16, m8, m32, wc;
    logic        o16, o8, o32, e16, e8, e32;
    logic [1:0]  st;

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [31:0] v,
                                            input int dw);
        logic fb;
        for (int i = dw - 1; i >= 0; i--) begin
            fb = c[15] ^ v[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_models();
        m16 = SEED; m8 = SEED8; m32 = SEED; wc = 16'd0;
        o16 = 1'b0; o8 = 1'b0; o32 = 1'b0;
        e16 = 1'b0; e8 = 1'b0; e32 = 1'b0;
        st  = S_IDLE;
    endtask

    task automatic check_state();
        check("wcnt16", wcnt16, wc);
        check("wcnt8", wcnt8, wc);
        check("wcnt32", wcnt32, wc);
        check("busy16", busy16, st == S_ACCUM);
        check("busy8", busy8, st == S_ACCUM);
        check("busy32", busy32, st == S_ACCUM);
        check("ok16", ok16, o16);
        check("ok8", ok8, o8);
        check("ok32", ok32, o32);
        check("err16", err16, e16);
        check("err8", err8, e8);
        check("err32", err32, e32);
        check("state16", st16, st);
        check("state32", st32, st);
    endtask

    // One clock: expected CRCs pushed before the edge, popped and compared after.
    task automatic cycle();
        exp16_q.push_back(m16);
        exp8_q.push_back(m8);
        exp32_q.push_back(m32);
        tick();
        check("crc16", crc16, exp16_q.pop_front());
        check("crc8", crc8, exp8_q.pop_front());
        check("crc32", crc32, exp32_q.pop_front());
        check_state();
    endtask

    task automatic apply_word(input logic [31:0] v);
        m16 = crc_ref(m16, v, 16);
        m8  = crc_ref(m8, v, 8);
        m32 = crc_ref(m32, v, 32);
        wc  = (wc == 16'hFFFF) ? wc : wc + 16'd1;
        st  = S_ACCUM;
    endtask

    task automatic word(input logic [31:0] v);
        enb = 1'b1;
        d   = v;
        apply_word(v);
        cycle();
        enb = 1'b0;
    endtask

    task automatic stb(input logic [15:0] cd, input logic en, input logic clr);
        chk_stb = 1'b1;
        chk_d   = cd;
        enb     = en;
        d       = $urandom;
        err_clr = clr;
        o16 = (cd == m16); e16 = (cd != m16) ? 1'b1 : (clr ? 1'b0 : e16);
        o8  = (cd == m8);  e8  = (cd != m8)  ? 1'b1 : (clr ? 1'b0 : e8);
        o32 = (cd == m32); e32 = (cd != m32) ? 1'b1 : (clr ? 1'b0 : e32);
        st  = S_DONE;
        cycle();
        chk_stb = 1'b0; enb = 1'b0; err_clr = 1'b0;
    endtask

    task automatic done_ignore();
        enb     = 1'b1;
        chk_stb = 1'b1;
        chk_d   = ~m16;
        d       = $urandom;
        cycle();
        enb = 1'b0; chk_stb = 1'b0;
    endtask

    task automatic rearm();
        arm = 1'b0;
        m16 = SEED; m8 = SEED8; m32 = SEED; wc = 16'd0;
        o16 = 1'b0; o8 = 1'b0; o32 = 1'b0;
        st  = S_IDLE;
        cycle();
        arm = 1'b1;
    endtask

    task automatic clr();
        err_clr = 1'b1;
        e16 = 1'b0; e8 = 1'b0; e32 = 1'b0;
        cycle();
        err_clr = 1'b0;
    endtask

    initial begin
        int len;
        rst_n = 1'b0; arm = 1'b0; enb = 1'b0; chk_stb = 1'b0;
        chk_d = '0; err_clr = 1'b0; d = '0;
        reset_models();
        repeat (3) @(posedge clk);
        #1;
        check("rst_crc16", crc16, SEED);
        check("rst_crc8", crc8, SEED8);
        check("rst_crc32", crc32, SEED);
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
        arm   = 1'b1;

        // zero-length burst compares against the seed
        stb(SEED, 1'b0, 1'b0);
        done_ignore();

        // four words, corrupted compare, re-arm keeps the error, then clear
        rearm();
        for (int i = 0; i < 4; i++) word($urandom);
        stb(m16 ^ 16'h0001, 1'b0, 1'b0);
        done_ignore();
        rearm();
        clr();

        // same-cycle data and check: check wins, word discarded
        for (int i = 0; i < 2; i++) word($urandom);
        stb(m16, 1'b1, 1'b0);

        // mismatch beats a same-cycle error clear
        rearm();
        word($urandom);
        stb(~m16, 1'b0, 1'b1);
        clr();

        // asynchronous reset mid-burst, then a fresh burst
        rearm();
        for (int i = 0; i < 5; i++) word($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        reset_models();
        check("arst_crc16", crc16, SEED);
        check("arst_crc8", crc8, SEED8);
        check("arst_crc32", crc32, SEED);
        check_state();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) word($urandom);
        stb(m16, 1'b0, 1'b0);

        // CRC-16/CCITT-FALSE check string on the byte-wide instance
        rearm();
        for (int b = 8'h31; b <= 8'h39; b++) word(32'(b));
        check("check_str_crc8", crc8, 16'h29B1);
        check("check_str_wcnt8", wcnt8, 16'd9);
        stb(16'h29B1, 1'b0, 1'b0);
        clr();

        // random bursts with idle gaps
        for (int b = 0; b < 4; b++) begin
            rearm();
            len = $urandom_range(0, 300);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) cycle();
                word($urandom);
            end
            stb((b % 2 == 1) ? m32 : m16, 1'b0, 1'b0);
            clr();
        end

        // word counter saturation
        rearm();
        enb = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            d = $urandom;
            apply_word(d);
            tick();
        end
        enb = 1'b0;
        check("sat_pre_wcnt16", wcnt16, 16'hFFFE);
        word($urandom);
        word($urandom);
        word($urandom);
        check("sat_wcnt16", wcnt16, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc_burst_chk.md
CRC_BURST_CHK -- requirements
Module: crc_burst_chk

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning data word width; legal values are 8, 16 and 32.
REQ-002 The block SHALL have parameter CW, default 16, meaning CRC width.
REQ-003 The block SHALL have parameter POLY, default 16'h1021, meaning the generator polynomial, implicit x^CW term.
REQ-004 The block SHALL have parameter SEED, default 16'h4ABA, meaning the CRC preset value.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 CLK4 SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 RESET_N SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-008 CRC_ARM SHALL be an input, 1 bit: low re-seeds the block synchronously; high allows accumulation.
REQ-009 CRC_ENB SHALL be an input, 1 bit: a data word on D is valid this cycle.
REQ-010 D SHALL be an input, DW bits: the data word.
REQ-011 CHK_STB SHALL be an input, 1 bit: the received CRC is presented on CHK_D this cycle.
REQ-012 CHK_D SHALL be an input, CW bits: the received CRC value to compare.
REQ-013 ERR_CLR SHALL be an input, 1 bit: clears CRC_ERR.
REQ-014 CRC_Q SHALL be an output, CW bits: the current CRC register.
REQ-015 WCNT SHALL be an output, 16 bits: the number of words accumulated in the current burst.
REQ-016 BUSY SHALL be an output, 1 bit: high in state ACCUM.
REQ-017 CRC_OK SHALL be an output, 1 bit: the last compare matched; valid in state DONE.
REQ-018 CRC_ERR SHALL be an output, 1 bit: sticky mismatch flag.

Function
REQ-019 The CRC step SHALL process D MSB-first, one bit per shift: fb = crc[CW-1] ^ d[i]; crc = (crc<<1) ^ (fb ? POLY : 0). No reflection and no final XOR.
REQ-020 A full DW-bit step SHALL complete in one cycle; CRC_Q SHALL show the updated value on the edge after CRC_ENB.
REQ-021 The state machine SHALL have three states: IDLE, ACCUM and DONE.
REQ-022 IDLE: CRC_Q = SEED and WCNT = 0. On CRC_ARM=1 with CRC_ENB=1 the block SHALL step the CRC, set WCNT = 1 and go to ACCUM.
REQ-023 ACCUM: each CRC_ENB=1 cycle SHALL step the CRC and increment WCNT; WCNT SHALL saturate at 16'hFFFF.
REQ-024 CHK_STB=1 in IDLE or ACCUM SHALL compare CHK_D with the pre-edge CRC_Q, set CRC_OK on match or CRC_ERR on mismatch one cycle later, and go to DONE.
REQ-025 When CHK_STB and CRC_ENB are both 1 in the same cycle, CHK_STB SHALL win: the data word is discarded and WCNT is unchanged.
REQ-026 CHK_STB in IDLE SHALL compare against SEED (zero-length burst).
REQ-027 DONE: CRC_Q, WCNT and CRC_OK SHALL hold; CRC_ENB and CHK_STB SHALL be ignored.
REQ-028 CRC_ARM=0 in any state SHALL, on the next edge, set state IDLE, CRC_Q = SEED, WCNT = 0 and CRC_OK = 0; CRC_ERR SHALL be unaffected; CRC_ARM=0 SHALL take priority over CRC_ENB and CHK_STB.
REQ-029 ERR_CLR=1 SHALL clear CRC_ERR on the next edge; a mismatch in the same cycle SHALL win and leave CRC_ERR = 1.
REQ-030 BUSY SHALL be 1 exactly while the state is ACCUM.

Reset
REQ-031 RESET_N=0 SHALL immediately force state IDLE, CRC_Q = SEED, WCNT = 0, BUSY = 0, CRC_OK = 0 and CRC_ERR = 0.
REQ-032 Reset asserted mid-burst SHALL discard all accumulation.
REQ-033 Release of RESET_N SHALL be synchronous to CLK4 at the system level.

Structure
REQ-034 Package crc_pkg SHALL hold the state encoding (IDLE, ACCUM, DONE) and the default POLY and SEED constants for ATA UDMA use.
REQ-035 The combinational DW-bit step SHALL be one sub-module, crc_step, with parameters DW, CW and POLY, inputs C and D, and output Q.
REQ-036 The top level SHALL contain only registers, the state machine, the counter and the comparator.

Verification
REQ-037 DW=8, SEED=16'hFFFF: feed ASCII "123456789" (0x31..0x39), one byte per cycle -> CRC_Q = 16'h29B1, WCNT = 9.
REQ-038 Default parameters: after reset, apply CHK_STB with CHK_D = 16'h4ABA and no data -> next cycle CRC_OK = 1, CRC_ERR = 0, state DONE.
REQ-039 Default parameters: 4 words, then CHK_STB with CHK_D = the model CRC XOR 16'h0001 -> CRC_ERR = 1; then CRC_ARM pulsed low -> CRC_Q = 16'h4ABA, WCNT = 0, CRC_ERR still 1; then ERR_CLR -> CRC_ERR = 0.
REQ-040 Same-cycle CRC_ENB and CHK_STB after 2 words -> compare uses the 2-word CRC, WCNT = 2, and the data word is not absorbed.
REQ-041 Assert RESET_N low asynchronously mid-burst (WCNT = 5) -> outputs take reset values before the next edge, and the following burst matches a fresh-seed model.
REQ-042 Randomised DW = 16 and DW = 32 bursts of length 0..300 against a bit-serial reference model -> CRC_Q matches every cycle; WCNT saturation forced -> WCNT holds at 16'hFFFF.
